bn_affine_stream: RTL and testbench
===================================

Name: bn_affine_stream

Overview:
- Streaming, pipelined batch-norm affine stage: y = act(sat(x*gamma + beta)) in signed fixed point.
- Per-channel gamma/beta come from a runtime-loadable coefficient table; they are not fixed at elaboration.
- Sits between the conv accumulator output and the next layer's input buffer.
- Processes LANES values of one channel per beat under valid/ready flow control.

Parameters:
- DATA_WIDTH, 16: signed element width for x, gamma, beta and y.
- FRAC_BITS, 8: fractional bits of every operand; 1.0 = 1<<FRAC_BITS.
- LANES, 4: elements per beat, all from the same channel.
- CHANNELS, 8: coefficient table depth and channel wrap point.
- SPATIAL, 16: beats per channel before the channel index advances.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  DATA_WIDTH*LANES  lane 0 in the MSBs.
- act_mode  in  2  0 = none, 1 = ReLU, 2 = leaky (slope 1/8), 3 = none; sampled with each accepted beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH*LANES  same lane order as in_data.
- out_ch  out  clog2(CHANNELS)  channel index of the out_data beat.
- out_last  out  1  last beat of the last channel (frame end).
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  clog2(CHANNELS)  channel to write.
- cfg_gamma  in  DATA_WIDTH  gamma value.
- cfg_beta  in  DATA_WIDTH  beta value.

Behaviour:
- Clocking and reset: single clk domain.
  - When reset=0 at a clk edge: every pipeline valid bit is cleared, out_valid=0, out_data=0, out_ch=0, out_last=0.
  - Reset also clears the beat counter and channel counter to 0.
  - Reset loads every table entry with gamma = 1<<FRAC_BITS, beta = 0, so the block is identity after reset.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Pipeline enable en = !out_valid || out_ready; in_ready = en.
  - A stall freezes all stages; no bubble removal.
  - out_data, out_ch and out_last stay stable while out_valid && !out_ready.
- Pipeline: 3 stages, latency exactly 3 cycles with out_ready held at 1.
  - S1: register x, act_mode, channel index and last flag; read gamma/beta for the current channel.
  - S2: per-lane full 2*DATA_WIDTH signed product x*gamma, then arithmetic shift right by FRAC_BITS (floor).
  - S3: add sign-extended beta in DATA_WIDTH+2 bits, then saturate to [-2^(DW-1), 2^(DW-1)-1].
  - S3 activation, applied after saturation:
    - ReLU: negative → 0.
    - Leaky: negative → arithmetic >>>3 (floor).
- Counters (advance only on an accepted beat):
  - beat_cnt counts 0..SPATIAL-1; on wrap, ch_cnt increments.
  - ch_cnt wraps CHANNELS-1 → 0.
  - The last flag is true when beat_cnt=SPATIAL-1 and ch_cnt=CHANNELS-1.
- Coefficient table:
  - The write takes effect at the clk edge.
  - If a write and an S1 read hit the same channel in the same cycle, the read returns the old value (read-first).
  - Writes are accepted regardless of stall.
  - Software must load the table before streaming a frame; mid-frame writes are legal but take effect per the rule above.
- Boundary conditions:
  - Product overflow is impossible in 2*DW bits. Only the post-add result saturates.
  - gamma = 0 gives a beta-only result.
  - Most negative input with gamma = -1.0 saturates to +max.
  - Reset asserted mid-frame discards every in-flight beat. The next accepted beat is channel 0, beat 0.

Test Plan:
- Defaults (DW=16, FRAC=8): after reset, stream x=0x0100 on all lanes, mode 0 → out_data lanes 0x0100 three cycles after acceptance, out_ch=0.
- Affine: write ch0 gamma=0x0200, beta=0x0080; x=0x0100, mode 0 → 0x0280. x=0xFF00 → 0xFE80.
- Saturation: gamma=0x0400, beta=0; x=0x7000 → 0x7FFF. x=0x8000 → 0x8000. gamma=0xFF00, x=0x8000 → 0x7FFF.
- Activation: gamma=0x0100, beta=0; x=0xFF00 with mode 1 → 0x0000; mode 2 → 0xFFE0; x=0x0100 with mode 2 → 0x0100.
- Counters (CHANNELS=2, SPATIAL=2): 8 back-to-back beats → out_ch sequence 0,0,1,1,0,0,1,1; out_last on beats 4 and 8; per-channel coefficients applied.
- Backpressure and reset: random out_ready toggling gives outputs identical to the no-stall run, held stable while stalled. Reset pulsed low for one cycle mid-frame → out_valid=0 next cycle; the next accepted beat is reported as out_ch=0 and uses the identity coefficients.

Source files
------------

// File: rtl/bn_affine_stream_if.sv
// Stream, handshake and coefficient-load signals for bn_affine_stream.
// master drives beats in and accepts results; slave is the block.
interface bn_affine_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int CHANNELS   = 8
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH*LANES-1:0]   in_data;
    logic [1:0]                    act_mode;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH*LANES-1:0]   out_data;
    logic [CW-1:0]                 out_ch;
    logic                          out_last;
    logic                          cfg_we;
    logic [CW-1:0]                 cfg_addr;
    logic [DATA_WIDTH-1:0]         cfg_gamma;
    logic [DATA_WIDTH-1:0]         cfg_beta;

    modport master (
        output in_valid, in_data, act_mode, out_ready,
        output cfg_we, cfg_addr, cfg_gamma, cfg_beta,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        input  in_valid, in_data, act_mode, out_ready,
        input  cfg_we, cfg_addr, cfg_gamma, cfg_beta,
        output in_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/bn_affine_stream.sv
// Streaming batch-norm affine stage: y = act(sat(x*gamma + beta)).
// Three stages (table read, scaled product, bias+saturate+activation).
module bn_affine_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4,
    parameter int CHANNELS   = 8,
    parameter int SPATIAL    = 16
) (
    input logic clk,
    input logic reset,
    bn_affine_stream_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = DW + 1;
    localparam int SW = DW + 2;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = (SPATIAL > 1) ? $clog2(SPATIAL) : 1;
    localparam logic [DW-1:0] ONE = DW'(1) << FRAC_BITS;

    typedef logic [LANES-1:0][DW-1:0] vec_t;
    typedef logic [LANES-1:0][PW-1:0] pvec_t;
    typedef struct packed {
        logic [1:0]    mode;
        logic [CW-1:0] ch;
        logic          last;
    } tag_t;

    logic [DW-1:0] gtab [CHANNELS];
    logic [DW-1:0] btab [CHANNELS];

    logic [BW-1:0] beat_cnt;
    logic [CW-1:0] ch_cnt;
    logic          beat_wrap, ch_wrap;
    logic          en, acc;

    logic          v1, v2, ov;
    vec_t          x1;
    logic [DW-1:0] g1, b1, b2;
    tag_t          t1, t2, tin;
    pvec_t         p2, pn;
    vec_t          y3, yn;
    logic [CW-1:0] och;
    logic          olast;

    logic signed [2*DW-1:0] prod, sh;
    logic [SW-1:0]          sum;
    logic [DW-1:0]          sat;

    assign en            = !ov || bus.out_ready;
    assign acc           = bus.in_valid && en;
    assign bus.in_ready  = en;
    assign bus.out_valid = ov;
    assign bus.out_data  = y3;
    assign bus.out_ch    = och;
    assign bus.out_last  = olast;

    assign beat_wrap = beat_cnt == BW'(SPATIAL - 1);
    assign ch_wrap   = ch_cnt == CW'(CHANNELS - 1);
    assign tin       = '{mode: bus.act_mode, ch: ch_cnt, last: beat_wrap && ch_wrap};

    // Table writes ignore stalls; S1 reads the pre-edge contents (read-first).
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                gtab[i] <= ONE;
                btab[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            gtab[bus.cfg_addr] <= bus.cfg_gamma;
            btab[bus.cfg_addr] <= bus.cfg_beta;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_cnt <= '0;
            ch_cnt   <= '0;
        end else if (acc) begin
            beat_cnt <= beat_wrap ? '0 : beat_cnt + 1'b1;
            if (beat_wrap) begin
                ch_cnt <= ch_wrap ? '0 : ch_cnt + 1'b1;
            end
        end
    end

    // Product clamped to DW+1 bits: any clamped value already saturates
    // after the bias add, so the narrow adder stays exact.
    always_comb begin
        prod = '0;
        sh   = '0;
        pn   = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = $signed({{DW{x1[i][DW-1]}}, x1[i]})
                 * $signed({{DW{g1[DW-1]}}, g1});
            sh   = prod >>> FRAC_BITS;
            if (sh[2*DW-1:DW] != {DW{sh[2*DW-1]}}) begin
                pn[i] = sh[2*DW-1] ? {1'b1, {DW{1'b0}}}
                                   : {1'b0, {DW{1'b1}}};
            end else begin
                pn[i] = sh[PW-1:0];
            end
        end
    end

    always_comb begin
        sum = '0;
        sat = '0;
        yn  = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = {p2[i][PW-1], p2[i]} + {{2{b2[DW-1]}}, b2};
            if (sum[SW-1:DW-1] != {3{sum[SW-1]}}) begin
                sat = sum[SW-1] ? {1'b1, {(DW-1){1'b0}}}
                                : {1'b0, {(DW-1){1'b1}}};
            end else begin
                sat = sum[DW-1:0];
            end
            unique case (1'b1)
                (t2.mode == 2'd1) && sat[DW-1]: yn[i] = '0;
                (t2.mode == 2'd2) && sat[DW-1]: yn[i] = {3'b111, sat[DW-1:3]};
                default:                        yn[i] = sat;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            ov    <= 1'b0;
            x1    <= '0;
            g1    <= '0;
            b1    <= '0;
            b2    <= '0;
            t1    <= '0;
            t2    <= '0;
            p2    <= '0;
            y3    <= '0;
            och   <= '0;
            olast <= 1'b0;
        end else if (en) begin
            v1    <= bus.in_valid;
            x1    <= bus.in_data;
            g1    <= gtab[ch_cnt];
            b1    <= btab[ch_cnt];
            t1    <= tin;
            v2    <= v1;
            p2    <= pn;
            b2    <= b1;
            t2    <= t1;
            ov    <= v2;
            y3    <= yn;
            och   <= t2.ch;
            olast <= v2 && t2.last;
        end
    end
endmodule

// File: tb/tb_bn_affine_stream.sv
// Bench for bn_affine_stream: arithmetic reference model plus
// hand-computed literal expectations on selected beats.
module tb_bn_affine_stream;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int C  = 2;
    localparam int S  = 2;
    localparam int CW = 1;

    typedef struct {
        logic [63:0] d;
        int          ch;
        bit          last;
        bit [2:0]    lm;
        logic [15:0] ld;
        int          lch;
        bit          llast;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bn_affine_stream_if #(.DATA_WIDTH(DW), .LANES(L), .CHANNELS(C)) bus();

    bn_affine_stream #(
        .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(L),
        .CHANNELS(C), .SPATIAL(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    int   mg[C];
    int   mb[C];
    int   n_acc = 0;
    bit   rnd_ready = 1'b0;
    bit   wr_pend = 1'b0;
    int   wr_a, wr_g, wr_b;

    function automatic logic [15:0] lane_f(logic [15:0] x, int g, int b, logic [1:0] m);
        longint p;
        longint s;
        p = (longint'($signed(x)) * longint'(g)) >>> 8;
        s = p + longint'(b);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (s < 0 && m == 2'd1) s = 0;
        else if (s < 0 && m == 2'd2) s = s >>> 3;
        return s[15:0];
    endfunction

    function automatic logic [63:0] model_beat(logic [63:0] x, logic [1:0] m, int g, int b);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = lane_f(x[16*i +: 16], g, b, m);
        return r;
    endfunction

    function automatic logic [63:0] rep4(logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic model_init();
        for (int i = 0; i < C; i++) begin
            mg[i] = 256;
            mb[i] = 0;
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [63:0] pd;
    logic [CW-1:0] pch;
    logic pl;
    bit pstall = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (!reset) begin
            pstall = 1'b0;
        end else begin
            if (pstall) begin
                chk("hold_valid", 64'(bus.out_valid), 64'(1));
                chk("hold_data", bus.out_data, pd);
                chk("hold_ch", 64'(bus.out_ch), 64'(pch));
                chk("hold_last", 64'(bus.out_last), 64'(pl));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h expected=none", bus.out_data);
                end else begin
                    e = q.pop_front();
                    chk("model_data", bus.out_data, e.d);
                    chk("model_ch", 64'(bus.out_ch), 64'(e.ch));
                    chk("model_last", 64'(bus.out_last), 64'(e.last));
                    if (e.lm[0]) chk("lit_lane0", 64'(bus.out_data[63:48]), 64'(e.ld));
                    if (e.lm[1]) chk("lit_ch", 64'(bus.out_ch), 64'(e.lch));
                    if (e.lm[2]) chk("lit_last", 64'(bus.out_last), 64'(e.llast));
                end
            end
            pstall = bus.out_valid && !bus.out_ready;
            pd  = bus.out_data;
            pch = bus.out_ch;
            pl  = bus.out_last;
        end
    end

    task automatic send(input logic [63:0] x, input logic [1:0] m, input bit [2:0] lm,
                        input logic [15:0] ld, input int lch, input bit llast);
        bit   acc;
        int   k;
        int   ch;
        exp_t n;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        bus.act_mode = m;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) begin
                ch = (n_acc / S) % C;
                n.d = model_beat(x, m, mg[ch], mb[ch]);
                n.ch = ch;
                n.last = (n_acc % (S * C)) == (S * C - 1);
                n.lm = lm;
                n.ld = ld;
                n.lch = lch;
                n.llast = llast;
                q.push_back(n);
                n_acc++;
            end
            if (wr_pend) begin
                mg[wr_a] = wr_g;
                mb[wr_a] = wr_b;
                wr_pend = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.cfg_we = 1'b0;
            k++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted");
        end
    endtask

    task automatic cfg_write(input int a, input logic [15:0] g, input logic [15:0] b);
        bus.in_valid  = 1'b0;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = CW'(a);
        bus.cfg_gamma = g;
        bus.cfg_beta  = b;
        @(negedge clk);
        mg[a] = int'($signed(g));
        mb[a] = int'($signed(b));
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 200 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b0;
        reset = 1'b0;
        q.delete();
        n_acc = 0;
        model_init();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.act_mode = 2'd0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_gamma = '0;
        bus.cfg_beta = '0;
        model_init();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_data", bus.out_data, 64'(0));
        chk("rst_ch", 64'(bus.out_ch), 64'(0));
        chk("rst_last", 64'(bus.out_last), 64'(0));
        @(posedge clk);
        #1;

        // identity after reset, latency
        send(rep4(16'h0100), 2'd0, 3'b011, 16'h0100, 0, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("latency_early", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        chk("latency_3", 64'(bus.out_valid), 64'(1));
        @(posedge clk);
        #1;
        drain();

        // affine
        do_reset();
        cfg_write(0, 16'h0200, 16'h0080);
        cfg_write(1, 16'h0200, 16'h0080);
        send(rep4(16'h0100), 2'd0, 3'b001, 16'h0280, 0, 0);
        send({16'hFF00, 16'h0100, 16'h7FFF, 16'h0000}, 2'd0, 3'b001, 16'hFE80, 0, 0);
        drain();

        // saturation and gamma = 0
        do_reset();
        cfg_write(0, 16'h0400, 16'h0000);
        cfg_write(1, 16'h0400, 16'h0000);
        send(rep4(16'h7000), 2'd0, 3'b001, 16'h7FFF, 0, 0);
        send(rep4(16'h8000), 2'd0, 3'b001, 16'h8000, 0, 0);
        cfg_write(0, 16'hFF00, 16'h0000);
        cfg_write(1, 16'hFF00, 16'h0000);
        send(rep4(16'h8000), 2'd0, 3'b001, 16'h7FFF, 0, 0);
        cfg_write(0, 16'h0000, 16'h0123);
        cfg_write(1, 16'h0000, 16'h0123);
        send(rep4(16'h5555), 2'd0, 3'b001, 16'h0123, 0, 0);
        drain();

        // activation
        do_reset();
        send(rep4(16'hFF00), 2'd1, 3'b001, 16'h0000, 0, 0);
        send(rep4(16'hFF00), 2'd2, 3'b001, 16'hFFE0, 0, 0);
        send(rep4(16'h0100), 2'd2, 3'b001, 16'h0100, 0, 0);
        send(rep4(16'hFF00), 2'd3, 3'b001, 16'hFF00, 0, 0);
        drain();

        // channel/beat counters and per-channel coefficients
        do_reset();
        cfg_write(0, 16'h0100, 16'h0000);
        cfg_write(1, 16'h0200, 16'h0010);
        for (int i = 0; i < 8; i++) begin
            send(rep4(16'h0100), 2'd0, 3'b111,
                 ((i / 2) % 2) ? 16'h0210 : 16'h0100, (i / 2) % 2, (i % 4) == 3);
        end
        drain();

        // same-cycle write and read of channel 0 returns the old entry
        do_reset();
        bus.cfg_we = 1'b1;
        bus.cfg_addr = '0;
        bus.cfg_gamma = 16'h0300;
        bus.cfg_beta = 16'h0000;
        wr_a = 0;
        wr_g = 768;
        wr_b = 0;
        wr_pend = 1'b1;
        send(rep4(16'h0100), 2'd0, 3'b011, 16'h0100, 0, 0);
        send(rep4(16'h0100), 2'd0, 3'b011, 16'h0300, 0, 0);
        drain();

        // random backpressure
        do_reset();
        cfg_write(0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        cfg_write(1, 16'h0180, 16'hFF40);
        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send({$urandom, $urandom}, 2'($urandom_range(0, 3)), 3'b000, 16'h0, 0, 0);
        end
        drain();
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;

        // reset mid-frame
        cfg_write(0, 16'h0200, 16'h0040);
        cfg_write(1, 16'h0300, 16'h0020);
        for (int i = 0; i < 3; i++) begin
            send(rep4(16'h0100), 2'd0, 3'b000, 16'h0, 0, 0);
        end
        do_reset();
        @(negedge clk);
        chk("rst_mid_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        send(rep4(16'h0100), 2'd0, 3'b111, 16'h0100, 0, 0);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
